sdfm_rd_sched: RTL and testbench

SDFM_RD_SCHED -- requirements
Module: sdfm_rd_sched

---
 rtl/sdfm_pkg.sv | 20 ++
 rtl/sdfm_wait_cnt.sv | 48 ++++
 rtl/sdfm_rd_sched.sv | 115 +++++++++++
 tb/tb_sdfm_rd_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdfm_pkg.sv
// Shared definitions for the two-channel sigma-delta read scheduler:
// FSM encoding, channel count, default word width and channel decode helper.
package sdfm_pkg;

    localparam int NUM_CH     = 2;
    localparam int DW_DEFAULT = 32;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } state_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdfm_wait_cnt.sv
// Per-channel wait counter with a sticky starvation flag. The counter runs while
// the channel requests without being served and saturates at WAIT_MAX.
module sdfm_wait_cnt
    import sdfm_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic active,
    input  logic grant,
    input  logic stat_clr,
    output logic starve
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starve_q, starve_d;
    logic             set;

    always_comb begin
        cnt_d = cnt_q;
        set   = 1'b0;
        if (!req || grant) begin
            cnt_d = '0;
        end else if (!active) begin
            cnt_d = (cnt_q >= MAX) ? MAX : cnt_q + 1'b1;
            // Holds every cycle the channel keeps waiting at saturation, so a clear loses.
            set   = (cnt_d == MAX);
        end
        starve_d = set | (starve_q & ~stat_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;

endmodule

// File: rtl/sdfm_rd_sched.sv
// Two-channel read scheduler: round-robin arbiter plus IDLE/RD/CAP/OUT FSM that
// strobes the granted channel FIFO, captures its word and holds it for the consumer.
module sdfm_rd_sched
    import sdfm_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int WAIT_MAX = 255
) (
    input  logic                 SYSCLK,
    input  logic                 SYSRSTn,
    input  logic                 en,
    input  logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH*DW-1:0] ch_data,
    output logic [NUM_CH-1:0]    fifo_rd,
    output logic [DW-1:0]        out_data,
    output logic                 out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_CH-1:0]    starve,
    input  logic [NUM_CH-1:0]    stat_clr,
    output logic                 busy
);

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [NUM_CH-1:0]   fifo_rd_q, fifo_rd_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic                out_ch_q, out_ch_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                sel;
    logic                take;

    // On a tie the channel opposite the last-served one wins.
    assign sel = (req == 2'b11) ? ~last_q : req[1];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        fifo_rd_d   = '0;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        take        = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && req != '0) begin
                    take      = 1'b1;
                    grant_d   = sel;
                    last_d    = sel;
                    fifo_rd_d = ch_onehot(sel);
                    state_d   = RD;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                out_data_d  = grant_q ? ch_data[2*DW-1:DW] : ch_data[DW-1:0];
                out_ch_d    = grant_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTn) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            fifo_rd_q   <= '0;
            out_data_q  <= '0;
            out_ch_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            fifo_rd_q   <= fifo_rd_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_wait
        sdfm_wait_cnt #(.WAIT_MAX(WAIT_MAX)) u_wait (
            .clk      (SYSCLK),
            .rst_n    (SYSRSTn),
            .req      (req[i]),
            .active   ((state_q != IDLE) && (grant_q == 1'(i))),
            .grant    (take && (sel == 1'(i))),
            .stat_clr (stat_clr[i]),
            .starve   (starve[i])
        );
    end

    assign fifo_rd   = fifo_rd_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sdfm_rd_sched.sv
// Scoreboard bench for sdfm_rd_sched: directed scenarios push expected strobes and
// words into queues; negedge monitors pop and compare whenever the DUT presents them.
module tb_sdfm_rd_sched;

    localparam int DW = 32;
    localparam logic [DW-1:0] D0 = 32'hA5A5_0001;
    localparam logic [DW-1:0] D1 = 32'h5A5A_0002;

    logic            SYSCLK = 1'b0;
    logic            SYSRSTn;
    logic            en;
    logic [1:0]      req;
    logic [2*DW-1:0] ch_data;
    logic [1:0]      fifo_rd;
    logic [DW-1:0]   out_data;
    logic            out_ch;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      starve;
    logic [1:0]      stat_clr;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    int              exp_rd_q[$];
    logic [DW:0]     exp_out_q[$];

    sdfm_rd_sched #(.DW(DW), .WAIT_MAX(8)) dut (
        .SYSCLK    (SYSCLK),
        .SYSRSTn   (SYSRSTn),
        .en        (en),
        .req       (req),
        .ch_data   (ch_data),
        .fifo_rd   (fifo_rd),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .starve    (starve),
        .stat_clr  (stat_clr),
        .busy      (busy)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic expect_xfer(input int ch, input bit with_out);
        exp_rd_q.push_back(ch);
        if (with_out) exp_out_q.push_back({ch[0], (ch == 1) ? D1 : D0});
    endtask

    // Strobe monitor: every fifo_rd pulse must be one-hot and match the next expected grant.
    always @(negedge SYSCLK) begin
        if (fifo_rd != 2'b00) begin
            chk("rd_onehot", 64'($onehot(fifo_rd)), 64'd1);
            if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'(fifo_rd), 64'd0);
            else begin
                int ch;
                ch = exp_rd_q.pop_front();
                chk("rd_chan", 64'(fifo_rd), (ch == 1) ? 64'd2 : 64'd1);
            end
        end
    end

    // Output monitor: compare on each accepted handshake.
    always @(negedge SYSCLK) begin
        if (out_valid && out_ready) begin
            if (exp_out_q.size() == 0) chk("out_unexpected", 64'(out_data), 64'd0);
            else begin
                logic [DW:0] e;
                e = exp_out_q.pop_front();
                chk("out_ch", 64'(out_ch), 64'(e[DW]));
                chk("out_data", 64'(out_data), 64'(e[DW-1:0]));
            end
        end
    end

    task automatic rst_pulse();
        req = 2'b00; stat_clr = 2'b00;
        SYSRSTn = 1'b0;
        tick();
        SYSRSTn = 1'b1;
    endtask

    initial begin
        int npulse, lastc;
        SYSRSTn = 1'b0; en = 1'b1; req = 2'b00; stat_clr = 2'b00; out_ready = 1'b1;
        ch_data = {D1, D0};
        tick(); tick();
        chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_starve", 64'(starve), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        SYSRSTn = 1'b1;
        tick();

        // Single request latency.
        expect_xfer(0, 1);
        req = 2'b01;
        tick();
        chk("t1_rd", 64'(fifo_rd), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        req = 2'b00;
        tick();
        chk("t1_cap_rd", 64'(fifo_rd), 64'd0);
        chk("t1_cap_valid", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'(D0));
        chk("t1_ch", 64'(out_ch), 64'd0);
        tick();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_idle_valid", 64'(out_valid), 64'd0);

        // Tie alternation from a fresh pointer: 0,1,0,1,...
        rst_pulse();
        for (int k = 0; k < 8; k++) expect_xfer(k % 2, 1);
        req = 2'b11;
        npulse = 0; lastc = 0;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (fifo_rd != 2'b00) begin
                npulse++;
                if (npulse > 1) chk("t2_period", 64'(c - lastc), 64'd4);
                lastc = c;
                if (npulse == 8) req = 2'b00;
            end
        end
        chk("t2_pulses", 64'(npulse), 64'd8);

        // Consumer stall holds the word and blocks new strobes.
        expect_xfer(0, 1);
        out_ready = 1'b0; req = 2'b01;
        tick();
        chk("t3_rd", 64'(fifo_rd), 64'd1);
        req = 2'b11;
        tick(); tick();
        for (int c = 0; c < 10; c++) begin
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_data", 64'(out_data), 64'(D0));
            chk("t3_no_rd", 64'(fifo_rd), 64'd0);
            tick();
        end
        req = 2'b00; out_ready = 1'b1;
        tick();
        chk("t3_release_busy", 64'(busy), 64'd0);
        chk("t3_release_valid", 64'(out_valid), 64'd0);

        // en dropped during RD: transfer finishes, then nothing until en returns.
        expect_xfer(1, 1);
        expect_xfer(0, 1);
        req = 2'b11; en = 1'b1;
        tick();
        chk("t4_rd", 64'(fifo_rd), 64'd2);
        en = 1'b0;
        tick(); tick(); tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t4_blocked_rd", 64'(fifo_rd), 64'd0);
            chk("t4_blocked_busy", 64'(busy), 64'd0);
        end
        en = 1'b1;
        tick();
        chk("t4_resume_rd", 64'(fifo_rd), 64'd1);
        req = 2'b00;
        tick(); tick(); tick();

        // Starvation of channel 1 with WAIT_MAX=8.
        rst_pulse();
        expect_xfer(0, 1);
        req = 2'b11; out_ready = 1'b0;
        tick();
        chk("t5_rd", 64'(fifo_rd), 64'd1);
        for (int c = 2; c <= 7; c++) tick();
        chk("t5_pre_starve", 64'(starve), 64'd0);
        tick();
        chk("t5_starve", 64'(starve), 64'd2);
        stat_clr = 2'b10;
        tick();
        chk("t5_clr_loses", 64'(starve), 64'd2);
        stat_clr = 2'b00; req = 2'b01;
        tick();
        chk("t5_sticky", 64'(starve), 64'd2);
        stat_clr = 2'b10;
        tick();
        chk("t5_cleared", 64'(starve), 64'd0);
        stat_clr = 2'b00; req = 2'b00; out_ready = 1'b1;
        tick();
        chk("t5_idle", 64'(busy), 64'd0);

        // Reset during CAP abandons the transfer and restores the tie pointer.
        expect_xfer(0, 0);
        req = 2'b01;
        tick();
        chk("t6_rd", 64'(fifo_rd), 64'd1);
        req = 2'b00;
        tick();
        SYSRSTn = 1'b0;
        tick();
        chk("t6_rst_rd", 64'(fifo_rd), 64'd0);
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_data", 64'(out_data), 64'd0);
        chk("t6_rst_ch", 64'(out_ch), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        SYSRSTn = 1'b1;
        expect_xfer(0, 1);
        req = 2'b11;
        tick();
        chk("t6_tie_ch0", 64'(fifo_rd), 64'd1);
        req = 2'b00;
        tick(); tick(); tick(); tick();

        chk("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
        chk("out_q_empty", 64'(exp_out_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
